uart_tx_param: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8N1 uart_tx. Adds configurable data width, parity, stop bits and baud divisor, a valid/ready input handshake and an internal FIFO so frames go out back-to-back. Sits between the host/register logic and the serial pin; serialises LSB-first frames onto tx_output.

---
 rtl/uart_tx_pkg.sv | 12 +
 rtl/uart_tx_fifo.sv | 42 ++++
 rtl/uart_tx_param.sv | 112 +++++++++++
 tb/tb_uart_tx_param.sv | 125 ++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state type, parity mode constants and parity helper
// for uart_tx_param and its sub-modules. No ports.
package uart_tx_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;
   // Word is zero-extended to 9 bits, so unused upper bits do not disturb the XOR.
   function automatic logic calc_parity(input logic [8:0] word, input int mode);
      return (mode == PAR_ODD) ? ~^word : ^word;
   endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO feeding the UART transmitter.
// Ports: clk/rst (sync active-high), push/wdata (ignored while full),
// pop/rdata (show-ahead read, ignored while empty), full, empty, count.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised LSB-first UART transmitter with input FIFO.
// Ports: tx_clk, RST (sync active-high), tx_data/tx_valid/tx_ready push handshake,
// tx_output serial line (idle high), tx_busy, clk_count baud counter, fifo_count.
// Optional macro UART_TX_CTS_EN adds tx_cts; new frames start only while it is high.
module uart_tx_param
   import uart_tx_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                              tx_clk,
   input  logic                              RST,
`ifdef UART_TX_CTS_EN
   input  logic                              tx_cts,
`endif
   input  logic [DATA_BITS-1:0]              tx_data,
   input  logic                              tx_valid,
   output logic                              tx_ready,
   output logic                              tx_output,
   output logic                              tx_busy,
   output logic [$clog2(CLKS_PER_BIT)-1:0]   clk_count,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   state_t state;
   logic [DATA_BITS-1:0] shift, rdata;
   logic [3:0] bit_idx;
   logic stop_idx, par, cts, full, empty, bit_end, frame_end, pop;
`ifdef UART_TX_CTS_EN
   assign cts = tx_cts;
`else
   assign cts = 1'b1;
`endif
   assign tx_ready  = !full;
   assign bit_end   = clk_count == LAST;
   assign frame_end = state == STOP && bit_end && stop_idx == 1'(STOP_BITS - 1);
   // Pop from IDLE, or straight out of the last stop bit for gapless frames.
   assign pop = !empty && cts && (state == IDLE || frame_end);
   uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (tx_clk),
      .rst   (RST),
      .push  (tx_valid),
      .pop   (pop),
      .wdata (tx_data),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );
   always_ff @(posedge tx_clk) begin
      if (RST) begin
         state     <= IDLE;
         tx_output <= 1'b1;
         tx_busy   <= 1'b0;
         clk_count <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         shift     <= '0;
         par       <= 1'b0;
      end else if (pop) begin
         state     <= START;
         tx_output <= 1'b0;
         tx_busy   <= 1'b1;
         clk_count <= '0;
         shift     <= rdata;
         par       <= calc_parity(9'(rdata), PARITY_MODE);
      end else if (state == IDLE) begin
         clk_count <= '0;
      end else if (!bit_end) begin
         clk_count <= clk_count + 1'b1;
      end else begin
         clk_count <= '0;
         case (state)
            START: begin
               state     <= DATA;
               bit_idx   <= '0;
               tx_output <= shift[0];
               shift     <= shift >> 1;
            end
            DATA: begin
               if (bit_idx == 4'(DATA_BITS - 1)) begin
                  state     <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                  tx_output <= (PARITY_MODE != PAR_NONE) ? par : 1'b1;
                  stop_idx  <= 1'b0;
               end else begin
                  bit_idx   <= bit_idx + 1'b1;
                  tx_output <= shift[0];
                  shift     <= shift >> 1;
               end
            end
            PARITY: begin
               state     <= STOP;
               tx_output <= 1'b1;
               stop_idx  <= 1'b0;
            end
            STOP: begin
               if (stop_idx == 1'(STOP_BITS - 1)) begin
                  state   <= IDLE;
                  tx_busy <= 1'b0;
               end else begin
                  stop_idx <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: three differently configured transmitters driven with shared stimulus
// and compared every cycle against a frame-timeline reference model.
module tb_uart_tx_param;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic valid = 1'b0;
   logic [8:0] din = '0;
   logic line [3];
   logic busy [3];
   logic ready [3];
   logic [2:0] fc [3];
   logic [1:0] cc [3];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int db_c [3]  = '{8, 8, 7};
   int cpb_c [3] = '{4, 4, 3};
   int par_c [3] = '{0, 2, 1};
   int stp_c [3] = '{1, 2, 1};
   int pend [3][$];
   bit act [3];
   int t_start [3];
   int cur_w [3];

   always #5 clk = ~clk;

   uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
      .tx_clk(clk), .RST(rst),
`ifdef UART_TX_CTS_EN
      .tx_cts(1'b1),
`endif
      .tx_data(din[7:0]), .tx_valid(valid), .tx_ready(ready[0]), .tx_output(line[0]),
      .tx_busy(busy[0]), .clk_count(cc[0]), .fifo_count(fc[0]));
   uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
      .tx_clk(clk), .RST(rst),
`ifdef UART_TX_CTS_EN
      .tx_cts(1'b1),
`endif
      .tx_data(din[7:0]), .tx_valid(valid), .tx_ready(ready[1]), .tx_output(line[1]),
      .tx_busy(busy[1]), .clk_count(cc[1]), .fifo_count(fc[1]));
   uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(3), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
      .tx_clk(clk), .RST(rst),
`ifdef UART_TX_CTS_EN
      .tx_cts(1'b1),
`endif
      .tx_data(din[6:0]), .tx_valid(valid), .tx_ready(ready[2]), .tx_output(line[2]),
      .tx_busy(busy[2]), .clk_count(cc[2]), .fifo_count(fc[2]));

   function automatic int flen(input int d);
      return cpb_c[d] * (1 + db_c[d] + ((par_c[d] != 0) ? 1 : 0) + stp_c[d]);
   endfunction

   // Bit i of a frame: start, data LSB first, optional parity, then stop bits.
   function automatic logic fbit(input int d, input int w, input int i);
      int ones;
      ones = $countones(w);
      if (i == 0) return 1'b0;
      if (i <= db_c[d]) return 1'((w >> (i - 1)) & 1);
      if (par_c[d] != 0 && i == db_c[d] + 1) return 1'((par_c[d] == 2) ? ones % 2 : 1 - ones % 2);
      return 1'b1;
   endfunction

   task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d cyc%0d got %0d expected %0d", tag, d, cyc, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [8:0] dat, input logic r);
      valid = v;
      din = dat;
      rst = r;
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
         if (r) begin
            pend[d].delete();
            act[d] = 1'b0;
         end else begin
            bit acc, done, take;
            acc  = v && pend[d].size() < DEPTH;
            done = act[d] && (cyc - t_start[d] == flen(d));
            take = pend[d].size() > 0 && (!act[d] || done);
            if (done) act[d] = 1'b0;
            if (take) begin
               cur_w[d] = pend[d].pop_front();
               t_start[d] = cyc;
               act[d] = 1'b1;
            end
            if (acc) pend[d].push_back(int'(dat) & ((1 << db_c[d]) - 1));
         end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         int e;
         e = cyc - t_start[d];
         check("line", d, 32'(line[d]), act[d] ? 32'(fbit(d, cur_w[d], e / cpb_c[d])) : 32'd1);
         check("busy", d, 32'(busy[d]), 32'(act[d]));
         check("clk_count", d, 32'(cc[d]), act[d] ? 32'(e % cpb_c[d]) : 32'd0);
         check("fifo_count", d, 32'(fc[d]), 32'(pend[d].size()));
         check("ready", d, 32'(ready[d]), 32'(pend[d].size() < DEPTH));
      end
   endtask

   initial begin
      repeat (3) step(1'b0, 9'h000, 1'b1);
      step(1'b1, 9'h051, 1'b0);
      repeat (60) step(1'b0, 9'($urandom), 1'b0);
      repeat (5) step(1'b1, 9'($urandom), 1'b0);
      repeat (300) step(1'b0, 9'h000, 1'b0);
      repeat (250) step(1'b1, 9'($urandom), 1'b0);
      repeat (250) step(1'b0, 9'h000, 1'b0);
      repeat (400) step($urandom_range(0, 3) == 0, 9'($urandom), 1'b0);
      repeat (250) step(1'b0, 9'h000, 1'b0);
      repeat (3) step(1'b1, 9'($urandom), 1'b0);
      repeat (12) step(1'b0, 9'h000, 1'b0);
      step(1'b0, 9'h000, 1'b1);
      repeat (80) step(1'b0, 9'h000, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
